// File: rtl/seq_gen.sv
// Parallel-to-serial word generator with selectable bit order, abort, and
// overlapping 4-bit pattern counting (1101 / 0110) over the emitted bits.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | ready for a new word; outputs quiet
//  SHIFT | one word bit per cycle on dout, bit index in bit_cnt
//  DONE  | single-cycle done pulse; hit_cnt is final
module seq_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din_par,
    input  logic             msb_first,
    input  logic             abort,
    output logic             ready,
    output logic             dout,
    output logic             dout_vld,
    output logic             done,
    output logic [5:0]       hit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FIRST_WIN = CW'(3);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic             msb_q;
    logic [CW-1:0]    bit_cnt;
    logic [2:0]       hist;
    logic [3:0]       window;
    logic             hit;
    logic             next_bit;

    // Oldest emitted bit sits in the window MSB; dout is the bit currently on the wire.
    assign window   = {hist, dout};
    assign hit      = (bit_cnt >= FIRST_WIN) && ((window == 4'b1101) || (window == 4'b0110));
    assign next_bit = msb_q ? sreg[WIDTH-1] : sreg[0];
    assign ready    = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sreg     <= '0;
            msb_q    <= 1'b0;
            bit_cnt  <= '0;
            hist     <= '0;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            done     <= 1'b0;
            hit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        // sreg holds the bits still to be emitted after the first one
                        sreg     <= msb_first ? (din_par << 1) : (din_par >> 1);
                        msb_q    <= msb_first;
                        dout     <= msb_first ? din_par[WIDTH-1] : din_par[0];
                        dout_vld <= 1'b1;
                        bit_cnt  <= '0;
                        hist     <= '0;
                        hit_cnt  <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        dout     <= 1'b0;
                        dout_vld <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        if (hit) begin
                            hit_cnt <= hit_cnt + 6'd1;
                        end
                        hist <= {hist[1:0], dout};
                        if (bit_cnt == LAST_BIT) begin
                            dout     <= 1'b0;
                            dout_vld <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            dout    <= next_bit;
                            sreg    <= msb_q ? (sreg << 1) : (sreg >> 1);
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    dout     <= 1'b0;
                    dout_vld <= 1'b0;
                    done     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
